axi_master_bridge: RTL
======================

AXI_MASTER_BRIDGE -- requirements
Module: axi_master_bridge

Interface
REQ-001 The block SHALL have parameter MASTER_ID, default 4'd0: value driven on AWID/ARID.
REQ-002 The block SHALL have parameter ID_W, default 4: width of AWID/ARID/BID/RID.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have core-side input ports core_req (1), core_we (1), core_addr (32), core_wdata (32) and core_wstrb (4): access request, write enable, byte address, write data and byte enables.
REQ-006 The block SHALL have core-side output ports core_rdata (32), core_stall (1) and core_err (1): read data, stall, and response error.
REQ-007 The block SHALL have AW channel ports AWID out ID_W, AWADDR out 32, AWLEN out 8, AWSIZE out 3, AWBURST out 2, AWVALID out 1 and AWREADY in 1.
REQ-008 The block SHALL have W channel ports WDATA out 32, WSTRB out 4, WLAST out 1, WVALID out 1 and WREADY in 1.
REQ-009 The block SHALL have B channel ports BID in ID_W, BRESP in 2, BVALID in 1 and BREADY out 1.
REQ-010 The block SHALL have AR channel ports ARID out ID_W, ARADDR out 32, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARVALID out 1 and ARREADY in 1.
REQ-011 The block SHALL have R channel ports RID in ID_W, RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1 and RREADY out 1.

Function
REQ-012 The block SHALL drive constants AWLEN=ARLEN=0, AWSIZE=ARSIZE=3'b010, AWBURST=ARBURST=2'b01, WLAST=1 and AWID=ARID=MASTER_ID (single-beat, 4-byte, INCR).
REQ-013 The FSM SHALL have states IDLE, RADDR, RDATA, WRITE, WRESP and DONE.
REQ-014 IDLE SHALL go to RADDR when core_req=1 and core_we=0, to WRITE when core_req=1 and core_we=1, and stay otherwise; the request fields are latched on exit from IDLE.
REQ-015 RADDR SHALL assert ARVALID with ARADDR = latched addr and SHALL go to RDATA on the cycle ARVALID&ARREADY.
REQ-016 RDATA SHALL assert RREADY and, on RVALID&RREADY, capture RDATA into core_rdata, record err = (RRESP!=2'b00) and go to DONE.
REQ-017 WRITE SHALL assert AWVALID and WVALID together; each SHALL deassert independently on the cycle after its own handshake, and the FSM SHALL go to WRESP once both handshakes have occurred, including both in the same cycle.
REQ-018 WRESP SHALL assert BREADY and, on BVALID, record err = (BRESP!=2'b00) and go to DONE.
REQ-019 DONE SHALL last exactly one cycle, drive core_err = recorded err, then return to IDLE; core_err SHALL be 0 in all other states.
REQ-020 core_stall SHALL equal 1 when (state==IDLE and core_req=1) or when state is not IDLE and not DONE; otherwise 0.
REQ-021 core_rdata SHALL hold its last captured value until the next read completes; writes SHALL not alter it.
REQ-022 The core SHALL hold its request stable while core_stall=1; the block SHALL not re-sample core inputs outside IDLE.
REQ-023 Minimum latency with ready/valid returned immediately SHALL be: request seen cycle 0, ARVALID/AWVALID+WVALID cycle 1, R/B accepted cycle 2, DONE (core_stall=0) cycle 3.
REQ-024 RID/BID SHALL not be checked; a response on the channel is accepted as the outstanding one.
REQ-025 VALID signals SHALL not depend combinationally on READY inputs, and no AXI signal SHALL change while VALID=1 and READY=0.

Reset
REQ-026 While rst=1 the block SHALL immediately (asynchronously) enter IDLE and force AWVALID=WVALID=ARVALID=BREADY=RREADY=0, core_err=0 and core_rdata=32'h0.
REQ-027 Reset asserted mid-transaction SHALL abandon it with no DONE cycle; the first request after rst falls SHALL be accepted normally.

Verification
REQ-028 Read, slave always ready, RDATA=32'hDEADBEEF, RRESP=0 -> ARADDR=req addr at cycle 1, core_stall 1 for cycles 0-2, core_rdata=DEADBEEF and core_stall=0 at cycle 3.
REQ-029 Write addr 0x0001_0004, wdata 0x12345678, wstrb 4'b0011, AWREADY 3 cycles after WREADY -> WVALID drops after its handshake, AWVALID held, exactly one B accepted, DONE reached once.
REQ-030 ARREADY held low 5 cycles -> ARVALID and ARADDR stable for all 5, stall stays 1, no RREADY before the AR handshake.
REQ-031 BRESP=2'b10 (SLVERR) -> core_err=1 for exactly the DONE cycle, 0 otherwise; same for RRESP=2'b11.
REQ-032 rst pulsed while in RDATA -> all valids/readys 0 within the same cycle, core_rdata=0, next read completes with correct data.
REQ-033 Back-to-back read then write with core_req held high -> second request accepted in the cycle after DONE, no AXI transaction issued during DONE.

Source files
------------

// File: rtl/axi_master_bridge.sv
// rtl/axi_master_bridge.sv - single-beat AXI4 master bridge for a simple stalling core bus
//
// Purpose: turns one core access (read or write) into a single-beat, 4-byte,
// INCR AXI4 transaction and stalls the core until the response returns.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   core_req/we/addr/wdata/wstrb   core request (held stable while core_stall=1)
//   core_rdata          last read data (held until the next read completes)
//   core_stall          core must wait while high
//   core_err            one-cycle error flag in the completion cycle
//   AW*/W*/B*           AXI write address, write data and write response channels
//   AR*/R*              AXI read address and read data channels
module axi_master_bridge #(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] MASTER_ID = 4'd0
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            core_req,
  input  logic            core_we,
  input  logic [31:0]     core_addr,
  input  logic [31:0]     core_wdata,
  input  logic [3:0]      core_wstrb,
  output logic [31:0]     core_rdata,
  output logic            core_stall,
  output logic            core_err,

  output logic [ID_W-1:0] AWID,
  output logic [31:0]     AWADDR,
  output logic [7:0]      AWLEN,
  output logic [2:0]      AWSIZE,
  output logic [1:0]      AWBURST,
  output logic            AWVALID,
  input  logic            AWREADY,

  output logic [31:0]     WDATA,
  output logic [3:0]      WSTRB,
  output logic            WLAST,
  output logic            WVALID,
  input  logic            WREADY,

  input  logic [ID_W-1:0] BID,
  input  logic [1:0]      BRESP,
  input  logic            BVALID,
  output logic            BREADY,

  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [7:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,

  input  logic [ID_W-1:0] RID,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RLAST,
  input  logic            RVALID,
  output logic            RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA_ST,
    WRITE,
    WRESP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;
  // Per-channel completion flags so AW and W can finish in either order.
  logic        aw_done;
  logic        w_done;

  // Only one transaction is ever outstanding, so response IDs and RLAST carry
  // no information.
  logic unused_ok;
  assign unused_ok = &{1'b0, BID, RID, RLAST};

  assign AWID    = MASTER_ID;
  assign ARID    = MASTER_ID;
  assign AWLEN   = 8'd0;
  assign ARLEN   = 8'd0;
  assign AWSIZE  = 3'b010;
  assign ARSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign ARBURST = 2'b01;
  assign WLAST   = 1'b1;

  // Payloads come only from registers latched when leaving IDLE, so they are
  // stable for as long as any VALID is waiting on READY.
  assign AWADDR     = addr_q;
  assign ARADDR     = addr_q;
  assign WDATA      = wdata_q;
  assign WSTRB      = wstrb_q;
  assign core_rdata = rdata_q;

  always_comb begin
    state_next = state;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    BREADY     = 1'b0;
    core_err   = 1'b0;
    core_stall = 1'b1;
    case (state)
      IDLE: begin
        core_stall = core_req;
        if (core_req) begin
          state_next = core_we ? WRITE : RADDR;
        end
      end
      RADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          state_next = RDATA_ST;
        end
      end
      RDATA_ST: begin
        RREADY = 1'b1;
        if (RVALID) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        // VALIDs depend on state and the done flags only, never on READY.
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if ((aw_done || AWREADY) && (w_done || WREADY)) begin
          state_next = WRESP;
        end
      end
      WRESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          state_next = DONE;
        end
      end
      DONE: begin
        core_stall = 1'b0;
        core_err   = err_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && core_req) begin
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
        wstrb_q <= core_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WRITE) begin
        if (AWVALID && AWREADY) begin
          aw_done <= 1'b1;
        end
        if (WVALID && WREADY) begin
          w_done <= 1'b1;
        end
      end
      if (state == RDATA_ST && RVALID) begin
        rdata_q <= RDATA;
        err_q   <= (RRESP != 2'b00);
      end
      if (state == WRESP && BVALID) begin
        err_q <= (BRESP != 2'b00);
      end
    end
  end

endmodule
